// File: rtl/ram_1p_arbiter_if.sv
// Host-port and RAM-port signal bundle for the two-host single-port RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the hosts and the RAM.
interface ram_1p_arbiter_if;
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_addr_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [63:0] host_rdata_o;
  logic [1:0]  host_err_o;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;

  modport slave (
    input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
           ram_rvalid_i, ram_rdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
           ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
           ram_rvalid_i, ram_rdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
           ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/ram_1p_arbiter.sv
// Round-robin arbiter that shares one single-cycle 32-bit RAM between two req/gnt/rvalid hosts.
// Accesses outside the RAM window get an error response and do not reach the RAM.
module ram_1p_arbiter #(
  parameter int unsigned Depth    = 128,
  parameter logic [31:0] BaseAddr = 32'h0010_0000
) (
  input logic             clk_i,
  input logic             rst_ni,
  ram_1p_arbiter_if.slave bus
);
  localparam int unsigned Aw = $clog2(Depth);
  localparam int unsigned Tw = 32 - Aw - 2;

  logic [1:0] w_in_win;
  logic       w_gnt_any;
  logic       w_gnt_host;
  logic       w_ram_req;
  logic       w_sel;

  logic r_last_winner;
  logic r_resp_valid;
  logic r_resp_host;
  logic r_resp_err;
  logic r_resp_we;

  always_comb begin
    w_in_win = '0;
    for (int unsigned h = 0; h < 2; h++) begin
      w_in_win[h] = (bus.host_addr_i[32*h+Aw+2 +: Tw] == BaseAddr[31:Aw+2]);
    end
  end

  always_comb begin
    w_gnt_any  = |bus.host_req_i;
    w_gnt_host = 1'b0;
    case (bus.host_req_i)
      2'b01:   w_gnt_host = 1'b0;
      2'b10:   w_gnt_host = 1'b1;
      2'b11:   w_gnt_host = ~r_last_winner;
      default: w_gnt_host = 1'b0;
    endcase
  end

  // When the RAM is idle, its command outputs follow host 0 so that they never float.
  always_comb begin
    w_ram_req = w_gnt_any & w_in_win[w_gnt_host];
    w_sel     = w_ram_req ? w_gnt_host : 1'b0;

    bus.host_gnt_o             = '0;
    bus.host_gnt_o[w_gnt_host] = w_gnt_any;

    bus.ram_req_o   = w_ram_req;
    bus.ram_we_o    = bus.host_we_i[w_sel];
    bus.ram_be_o    = bus.host_be_i[4*w_sel +: 4];
    bus.ram_addr_o  = bus.host_addr_i[32*w_sel +: 32];
    bus.ram_wdata_o = bus.host_wdata_i[32*w_sel +: 32];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_winner <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_host   <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_we     <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_last_winner <= w_gnt_host;
      end
      r_resp_valid <= w_gnt_any;
      r_resp_host  <= w_gnt_host;
      r_resp_err   <= ~w_in_win[w_gnt_host];
      r_resp_we    <= bus.host_we_i[w_gnt_host];
    end
  end

  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    bus.host_rdata_o  = '0;
    bus.host_rvalid_o[r_resp_host] = r_resp_valid;
    bus.host_err_o[r_resp_host]    = r_resp_valid & r_resp_err;
    if (r_resp_valid && !r_resp_err && !r_resp_we) begin
      bus.host_rdata_o[32*r_resp_host +: 32] = bus.ram_rdata_i;
    end
  end

  // The RAM ack is never used to generate rvalid. It must agree with the in-window response schedule.
  a_ram_ack_consistent: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.ram_rvalid_i == (r_resp_valid & ~r_resp_err)
  );
endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Randomized and directed bench for ram_1p_arbiter.
// A shadow memory and a round-robin scoreboard predict grants, RAM commands and responses.
module tb_ram_1p_arbiter;
  localparam int unsigned Depth = 128;
  localparam logic [31:0] Base  = 32'h0010_0000;
  localparam logic [31:0] Top   = Base + Depth * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_1p_arbiter_if bus();

  ram_1p_arbiter #(.Depth(Depth), .BaseAddr(Base)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Behavioural single-cycle RAM behind the arbiter
  logic [31:0] mem [Depth];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_rvalid_i <= 1'b0;
      bus.ram_rdata_i  <= '0;
    end else begin
      bus.ram_rvalid_i <= bus.ram_req_o;
      if (bus.ram_req_o) begin
        if (bus.ram_we_o) begin
          for (int b = 0; b < 4; b++)
            if (bus.ram_be_o[b]) mem[bus.ram_addr_o[8:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
        end else begin
          bus.ram_rdata_i <= mem[bus.ram_addr_o[8:2]];
        end
      end
    end
  end

  // Reference state
  logic [31:0] exp_mem [Depth];
  bit          exp_last;
  bit          p_valid, p_host, p_err;
  logic [31:0] p_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic [1:0] req, input logic [1:0] we, input logic [7:0] be,
                       input logic [63:0] addr, input logic [63:0] wdata);
    bit          g_any, g, inw;
    logic [1:0]  eg;
    logic [31:0] a;
    logic [63:0] e_rv, e_err, e_rd;
    int unsigned w;
    @(negedge clk);
    bus.host_req_i   = req;
    bus.host_we_i    = we;
    bus.host_be_i    = be;
    bus.host_addr_i  = addr;
    bus.host_wdata_i = wdata;
    #1;
    e_rv  = '0;
    e_err = '0;
    e_rd  = '0;
    if (p_valid) begin
      e_rv[p_host]  = 1'b1;
      e_err[p_host] = p_err;
      e_rd[32*p_host +: 32] = p_rdata;
    end
    chk("rvalid", 64'(bus.host_rvalid_o), e_rv);
    chk("err", 64'(bus.host_err_o), e_err);
    chk("rdata", bus.host_rdata_o, e_rd);

    g_any = (req != 2'b00);
    g     = (req == 2'b11) ? !exp_last : req[1];
    eg    = '0;
    if (g_any) eg[g] = 1'b1;
    chk("gnt", 64'(bus.host_gnt_o), 64'(eg));

    a   = addr[32*g +: 32];
    inw = g_any && (a >= Base) && (a < Top);
    chk("ram_req", 64'(bus.ram_req_o), 64'(inw));
    if (inw) begin
      chk("ram_addr", 64'(bus.ram_addr_o), 64'(a));
      chk("ram_we", 64'(bus.ram_we_o), 64'(we[g]));
      chk("ram_be", 64'(bus.ram_be_o), 64'(be[4*g +: 4]));
      chk("ram_wdata", 64'(bus.ram_wdata_o), 64'(wdata[32*g +: 32]));
    end else begin
      chk("ram_addr_idle", 64'(bus.ram_addr_o), 64'(addr[31:0]));
    end

    p_valid = g_any;
    p_host  = g;
    p_err   = !inw;
    p_rdata = '0;
    if (g_any) begin
      exp_last = g;
      if (inw) begin
        w = (a - Base) >> 2;
        if (we[g]) begin
          for (int b = 0; b < 4; b++)
            if (be[4*g+b]) exp_mem[w][8*b +: 8] = wdata[32*g+8*b +: 8];
        end else begin
          p_rdata = exp_mem[w];
        end
      end
    end
  endtask

  task automatic idle();
    cycle(2'b00, 2'b00, 8'h00, 64'h0, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    bus.host_req_i   = '0;
    bus.host_we_i    = '0;
    bus.host_be_i    = '0;
    bus.host_addr_i  = '0;
    bus.host_wdata_i = '0;
    #1;
    chk("rst_rvalid", 64'(bus.host_rvalid_o), 64'h0);
    chk("rst_err", 64'(bus.host_err_o), 64'h0);
    chk("rst_rdata", bus.host_rdata_o, 64'h0);
    chk("rst_gnt", 64'(bus.host_gnt_o), 64'h0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    p_valid  = 1'b0;
    exp_last = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return Base - 32'($urandom_range(1, 64));
      1:       return Top + 32'($urandom_range(0, 64));
      2:       return 32'($urandom);
      default: return Base + 32'($urandom_range(0, Depth * 4 - 1));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    do_reset();

    // Host 0 alone: write three words, then read them back-to-back
    cycle(2'b01, 2'b01, 8'h0F, {32'h0, Base + 32'h4}, {32'h0, 32'hA1A1_0004});
    cycle(2'b01, 2'b01, 8'h0F, {32'h0, Base + 32'h8}, {32'h0, 32'hB2B2_0008});
    cycle(2'b01, 2'b01, 8'h0F, {32'h0, Base + 32'hC}, {32'h0, 32'hC3C3_000C});
    cycle(2'b01, 2'b00, 8'h0F, {32'h0, Base + 32'h4}, 64'h0);
    cycle(2'b01, 2'b00, 8'h0F, {32'h0, Base + 32'h8}, 64'h0);
    chk("t1_rd4", 64'(bus.host_rdata_o[31:0]), 64'hA1A1_0004);
    cycle(2'b01, 2'b00, 8'h0F, {32'h0, Base + 32'hC}, 64'h0);
    chk("t1_rd8", 64'(bus.host_rdata_o[31:0]), 64'hB2B2_0008);
    idle();
    chk("t1_rdC", 64'(bus.host_rdata_o[31:0]), 64'hC3C3_000C);

    // Continuous contention straight out of reset alternates 0,1,0,1
    do_reset();
    cycle(2'b11, 2'b00, 8'hFF, {Base + 32'h20, Base + 32'h4}, 64'h0);
    chk("t2_first", 64'(bus.host_gnt_o), 64'h1);
    for (int i = 0; i < 5; i++)
      cycle(2'b11, 2'b00, 8'hFF, {Base + 32'(4 * i), Base + 32'(4 * i + 8)}, 64'h0);
    idle();

    // Byte-enable write from host 1 over a zeroed word
    cycle(2'b10, 2'b10, 8'hF0, {Base + 32'h10, 32'h0}, 64'h0);
    cycle(2'b10, 2'b10, 8'h50, {Base + 32'h10, 32'h0}, {32'hAABB_CCDD, 32'h0});
    chk("t3_wr_err", 64'(bus.host_err_o), 64'h0);
    cycle(2'b10, 2'b00, 8'hF0, {Base + 32'h10, 32'h0}, 64'h0);
    chk("t3_wr_rdata", bus.host_rdata_o, 64'h0);
    idle();
    chk("t3_bytes", 64'(bus.host_rdata_o[63:32]), 64'h00BB_00DD);

    // Out-of-window read at the first address past the window
    cycle(2'b01, 2'b00, 8'h0F, {32'h0, Top}, 64'h0);
    chk("t4_noreq", 64'(bus.ram_req_o), 64'h0);
    idle();
    chk("t4_err", 64'(bus.host_err_o), 64'h1);

    // Contention with host 0 out of window and host 1 in window
    cycle(2'b11, 2'b11, 8'hFF, {Base + 32'h20, Base - 32'h4}, {32'h1234_5678, 32'h9ABC_DEF0});
    cycle(2'b11, 2'b11, 8'hFF, {Base + 32'h20, Base - 32'h4}, {32'h1234_5678, 32'h9ABC_DEF0});
    idle();

    // Reset right after a grant that leaves host 0 as last winner
    cycle(2'b01, 2'b00, 8'h0F, {32'h0, Base + 32'h4}, 64'h0);
    do_reset();
    idle();
    cycle(2'b11, 2'b00, 8'hFF, {Base + 32'h8, Base + 32'hC}, 64'h0);
    chk("t6_gnt", 64'(bus.host_gnt_o), 64'h1);
    idle();

    for (int i = 0; i < 600; i++)
      cycle(2'($urandom), 2'($urandom), 8'($urandom), {rnd_addr(), rnd_addr()},
            {32'($urandom), 32'($urandom)});
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
